// File: rtl/mh_pkg.sv
// mh_pkg: shared types and helpers for the micro_hash initiator side.
package mh_pkg;
   localparam int BLOCK_BYTES = 16;
   localparam int ENTRY_BYTES = 12;
   localparam int NONCE_BYTES = 4;
   localparam int HASH_BYTES  = 3;

   typedef enum logic [2:0] {IDLE, LOAD, RUN, SETTLE, CHECK, DONE} mh_state_e;

   // Entry bytes 0..11 sit in the low bits; the nonce fills bytes 12..15 little-endian.
   function automatic logic [BLOCK_BYTES*8-1:0] pack_block(
      input logic [ENTRY_BYTES*8-1:0] entry,
      input logic [NONCE_BYTES*8-1:0] nonce
   );
      return {nonce, entry};
   endfunction
endpackage

// File: rtl/mh_target_cmp.sv
// mh_target_cmp: pass when hash bytes 0 and 1 are both strictly below target (unsigned).
// Byte 2 does not take part in the decision.
module mh_target_cmp
   import mh_pkg::*;
(
   input  logic [HASH_BYTES*8-1:0] hash,
   input  logic [7:0]              target,
   output logic                    pass
);
   logic unused_hi;

   assign unused_hi = ^hash[23:16];
   assign pass      = (hash[7:0] < target) && (hash[15:8] < target);
endmodule

// File: rtl/nonce_search_ctrl.sv
// nonce_search_ctrl: sweeps nonces through the micro_hash core until a hash
// meets target, the nonce range is exhausted, or the core stops answering.
module nonce_search_ctrl
   import mh_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int TIMEOUT       = 127
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         abort,
   input  logic [95:0]  entry_12,
   input  logic [31:0]  nonce_start,
   input  logic [31:0]  nonce_limit,
   input  logic [7:0]   target,
   input  logic         hash_done,
   input  logic [23:0]  hash_in,
   output logic         hash_reset_n,
   output logic [127:0] block,
   output logic         busy,
   output logic         result_valid,
   output logic         found,
   output logic         exhausted,
   output logic         timeout,
   output logic [31:0]  nonce_out,
   output logic [23:0]  hash_out
);
   localparam logic [6:0] TMO_LAST    = 7'(TIMEOUT);
   localparam logic [6:0] SETTLE_LAST = 7'(SETTLE_CYCLES - 1);

   mh_state_e   state, state_nx;
   logic [95:0] entry_q;
   logic [31:0] nonce, limit_q;
   logic [6:0]  cnt;
   logic        pass;
   logic        accept, load_en, cnt_clr, cnt_inc, nonce_inc, chk_en;
   logic        fin_found, fin_exh, fin_tmo;

   mh_target_cmp u_cmp (.hash(hash_in), .target(target), .pass(pass));

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next state and per-cycle strobes; abort squashes every strobe and returns to IDLE
   always_comb begin
      state_nx  = state;
      accept    = 1'b0;
      load_en   = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      nonce_inc = 1'b0;
      chk_en    = 1'b0;
      fin_found = 1'b0;
      fin_exh   = 1'b0;
      fin_tmo   = 1'b0;
      case (state)
         IDLE, DONE: if (start) begin accept = 1'b1; state_nx = LOAD; end
         LOAD: begin
            load_en  = 1'b1;
            cnt_clr  = 1'b1;
            state_nx = RUN;
         end
         RUN: begin
            if (hash_done) begin
               cnt_clr  = 1'b1;
               state_nx = SETTLE;
            end else if (cnt == TMO_LAST) begin
               fin_tmo  = 1'b1;
               state_nx = DONE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         SETTLE: begin
            if (cnt == SETTLE_LAST) state_nx = CHECK;
            else                    cnt_inc  = 1'b1;
         end
         CHECK: begin
            chk_en = 1'b1;
            if (pass) begin
               fin_found = 1'b1;
               state_nx  = DONE;
            end else if (nonce == limit_q) begin
               fin_exh  = 1'b1;
               state_nx = DONE;
            end else begin
               nonce_inc = 1'b1;
               state_nx  = LOAD;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (abort) begin
         state_nx  = IDLE;
         accept    = 1'b0;
         load_en   = 1'b0;
         cnt_clr   = 1'b0;
         cnt_inc   = 1'b0;
         nonce_inc = 1'b0;
         chk_en    = 1'b0;
         fin_found = 1'b0;
         fin_exh   = 1'b0;
         fin_tmo   = 1'b0;
      end
   end

   assign busy = (state != IDLE) && (state != DONE);
   // Core is released only while an attempt is in flight, so its result stays valid through CHECK
   assign hash_reset_n = (state == RUN) || (state == SETTLE) || (state == CHECK);

   // Datapath: latched search params, cycle counter, block and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         entry_q      <= '0;
         nonce        <= '0;
         limit_q      <= '0;
         cnt          <= '0;
         block        <= '0;
         result_valid <= 1'b0;
         found        <= 1'b0;
         exhausted    <= 1'b0;
         timeout      <= 1'b0;
         nonce_out    <= '0;
         hash_out     <= '0;
      end else begin
         result_valid <= fin_found | fin_exh | fin_tmo;
         if (abort) begin
            found     <= 1'b0;
            exhausted <= 1'b0;
            timeout   <= 1'b0;
         end else begin
            if (accept) begin
               entry_q   <= entry_12;
               nonce     <= nonce_start;
               limit_q   <= nonce_limit;
               found     <= 1'b0;
               exhausted <= 1'b0;
               timeout   <= 1'b0;
            end
            if (load_en)        block <= pack_block(entry_q, nonce);
            if (cnt_clr)        cnt   <= '0;
            else if (cnt_inc)   cnt   <= cnt + 7'd1;
            if (nonce_inc)      nonce <= nonce + 32'd1;
            if (chk_en) begin
               hash_out  <= hash_in;
               nonce_out <= nonce;
            end
            if (fin_found) found     <= 1'b1;
            if (fin_exh)   exhausted <= 1'b1;
            if (fin_tmo)   timeout   <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_nonce_search_ctrl.sv
// tb_nonce_search_ctrl: directed searches against a behavioural micro_hash core;
// expected results are queued at launch and checked by a monitor on result_valid.
`timescale 1ns/1ps
module tb_nonce_search_ctrl;
   logic         clk = 1'b0;
   logic         reset, start, abort;
   logic [95:0]  entry_12;
   logic [31:0]  nonce_start, nonce_limit;
   logic [7:0]   target;
   logic         hash_done = 1'b0;
   logic [23:0]  hash_in = 24'hFFFFFF;
   logic         hash_reset_n;
   logic [127:0] block;
   logic         busy, result_valid, found, exhausted, timeout;
   logic [31:0]  nonce_out;
   logic [23:0]  hash_out;

   logic [95:0]  E1 = 96'h0B0A09080706050403020100;
   logic [95:0]  E2 = 96'hDEADBEEFCAFEF00D12345678;

   nonce_search_ctrl #(.SETTLE_CYCLES(2), .TIMEOUT(127)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .entry_12(entry_12), .nonce_start(nonce_start), .nonce_limit(nonce_limit),
      .target(target), .hash_done(hash_done), .hash_in(hash_in),
      .hash_reset_n(hash_reset_n), .block(block), .busy(busy),
      .result_valid(result_valid), .found(found), .exhausted(exhausted),
      .timeout(timeout), .nonce_out(nonce_out), .hash_out(hash_out)
   );

   always #5 clk = ~clk;

   int n_pass = 0, n_tot = 0;
   int cyc = 0, start_cyc = 0, run_cyc = 0, last_rv_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   // Core model: done rises lat cycles after release; result valid SETTLE_CYCLES+1 cycles later
   int          lat  = 4;
   bit          hang = 1'b0;
   logic [23:0] hdef = 24'h505050;
   logic [23:0] hmap [logic [31:0]];
   int          ccnt = 0;

   function automatic logic [23:0] lookup(input logic [31:0] n);
      if (hmap.exists(n)) return hmap[n];
      return hdef;
   endfunction

   always @(posedge clk) begin
      if (hash_reset_n !== 1'b1) begin
         ccnt      <= 0;
         hash_done <= 1'b0;
         hash_in   <= 24'hFFFFFF;
      end else begin
         if (ccnt < 10000) ccnt <= ccnt + 1;
         hash_done <= !hang && (ccnt + 1 >= lat);
         hash_in   <= (ccnt + 1 >= lat + 3) ? lookup(block[127:96]) : 24'hFFFFFF;
      end
   end

   // Attempt logger: one entry per core release
   logic [31:0] tried[$];
   logic        hrn_seen = 1'b0;
   always @(negedge clk) begin
      if (hash_reset_n === 1'b1 && !hrn_seen) begin
         tried.push_back(block[127:96]);
         run_cyc = cyc;
      end
      hrn_seen = (hash_reset_n === 1'b1);
   end

   // Scoreboard monitor
   typedef struct {
      string       tag;
      bit          f, x, t, d;
      logic [31:0] n;
      logic [23:0] h;
   } exp_t;
   exp_t exp_q[$];
   exp_t e;
   logic rv_prev = 1'b0;

   always @(negedge clk) begin
      if (result_valid === 1'b1) begin
         last_rv_cyc = cyc;
         chk("result_valid_single_pulse", rv_prev, 1'b0);
         chk("result_valid_expected", exp_q.size() > 0, 1'b1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, "_found"}, found, e.f);
            chk({e.tag, "_exhausted"}, exhausted, e.x);
            chk({e.tag, "_timeout"}, timeout, e.t);
            if (e.d) begin
               chk({e.tag, "_nonce_out"}, nonce_out, e.n);
               chk({e.tag, "_hash_out"}, hash_out, e.h);
            end
         end
      end
      rv_prev = result_valid;
   end

   task automatic expect_res(input string tag, input bit f, input bit x, input bit t, input bit d,
                             input logic [31:0] n, input logic [23:0] h);
      exp_t ee;
      ee.tag = tag; ee.f = f; ee.x = x; ee.t = t; ee.d = d; ee.n = n; ee.h = h;
      exp_q.push_back(ee);
   endtask

   task automatic launch(input logic [31:0] ns, input logic [31:0] nl, input logic [7:0] tgt);
      @(negedge clk);
      nonce_start = ns; nonce_limit = nl; target = tgt; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      start_cyc = cyc;
      tried.delete();
   endtask

   task automatic wait_res(input string tag);
      for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(posedge clk);
      chk({tag, "_completed"}, exp_q.size() == 0, 1'b1);
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic wait_run(input string tag);
      for (int i = 0; i < 500 && hash_reset_n !== 1'b1; i++) @(negedge clk);
      chk({tag, "_run_reached"}, hash_reset_n, 1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_tot);
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; entry_12 = E1;
      nonce_start = '0; nonce_limit = '0; target = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_hash_reset_n", hash_reset_n, 1'b0);
      chk("rst_block", block, 128'h0);
      chk("rst_result_valid", result_valid, 1'b0);
      chk("rst_flags", {found, exhausted, timeout}, 3'b000);
      chk("rst_nonce_out", nonce_out, 32'h0);
      chk("rst_hash_out", hash_out, 24'h0);
      reset = 1'b0;

      // 1: single passing attempt, latency 1 + (66+1) + 2 + 1
      lat = 66; hmap.delete(); hdef = 24'h505050; hmap[32'd5] = 24'h302010;
      expect_res("t1", 1, 0, 0, 1, 32'd5, 24'h302010);
      launch(32'd5, 32'd100, 8'h40);
      chk("t1_busy_in_load", busy, 1'b1);
      chk("t1_core_held_in_load", hash_reset_n, 1'b0);
      wait_res("t1");
      chk("t1_latency", last_rv_cyc - start_cyc, 71);
      chk("t1_block", block, {32'h5, E1});
      chk("t1_attempts", tried.size(), 1);
      repeat (3) @(negedge clk);
      chk("t1_found_held", found, 1'b1);
      chk("t1_busy_done", busy, 1'b0);
      chk("t1_core_reset_done", hash_reset_n, 1'b0);

      // 2: target 0 never passes -> exhaust 10..12
      lat = 4; hmap.delete(); hdef = 24'h000000;
      expect_res("t2", 0, 1, 0, 1, 32'd12, 24'h000000);
      launch(32'd10, 32'd12, 8'h00);
      wait_res("t2");
      chk("t2_attempts", tried.size(), 3);
      chk("t2_try0", tried[0], 32'd10);
      chk("t2_try2", tried[2], 32'd12);

      // 3: wrap FFFFFFFF -> 0 -> 1
      hmap.delete(); hdef = 24'h505050; hmap[32'd1] = 24'h001010;
      expect_res("t3", 1, 0, 0, 1, 32'd1, 24'h001010);
      launch(32'hFFFFFFFF, 32'd1, 8'h40);
      wait_res("t3");
      chk("t3_attempts", tried.size(), 3);
      chk("t3_try0", tried[0], 32'hFFFFFFFF);
      chk("t3_try1", tried[1], 32'h0);
      chk("t3_try2", tried[2], 32'h1);

      // 4: core never finishes
      hang = 1'b1;
      expect_res("t4", 0, 0, 1, 0, 32'd0, 24'h0);
      launch(32'd7, 32'd7, 8'h40);
      wait_res("t4");
      chk("t4_timeout_cycles", last_rv_cyc - run_cyc, 128);
      hang = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t4_abort_in_done_clears", timeout, 1'b0);

      // 5a: abort in RUN
      lat = 20;
      launch(32'd3, 32'd3, 8'h40);
      wait_run("t5a");
      repeat (2) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t5a_busy", busy, 1'b0);
      chk("t5a_core_reset", hash_reset_n, 1'b0);
      chk("t5a_flags", {found, exhausted, timeout}, 3'b000);
      repeat (30) @(negedge clk);
      chk("t5a_stays_idle", busy, 1'b0);

      // 5b: reset while in SETTLE
      lat = 6; hmap.delete(); hmap[32'd60] = 24'h001111;
      launch(32'd60, 32'd60, 8'h40);
      for (int i = 0; i < 200 && hash_done !== 1'b1; i++) @(negedge clk);
      chk("t5b_done_reached", hash_done, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t5b_busy", busy, 1'b0);
      chk("t5b_core_reset", hash_reset_n, 1'b0);
      chk("t5b_nonce_out", nonce_out, 32'h0);
      chk("t5b_hash_out", hash_out, 24'h0);
      repeat (10) @(negedge clk);

      // 5c: start mid-search ignored; entry latched; target live at CHECK
      lat = 10; hmap.delete(); hmap[32'd50] = 24'h002020;
      expect_res("t5c", 1, 0, 0, 1, 32'd50, 24'h002020);
      launch(32'd50, 32'd50, 8'h10);
      wait_run("t5c");
      @(negedge clk);
      start = 1'b1; nonce_start = 32'd99; nonce_limit = 32'd99; entry_12 = E2; target = 8'h40;
      @(negedge clk);
      start = 1'b0;
      wait_res("t5c");
      chk("t5c_block", block, {32'd50, E1});
      chk("t5c_attempts", tried.size(), 1);
      entry_12 = E1;

      // 6: strict less-than on byte0/byte1
      lat = 3; hmap.delete(); hdef = 24'h505050;
      hmap[32'd20] = 24'h00403F; hmap[32'd21] = 24'h003F40; hmap[32'd22] = 24'hAA3F3F;
      expect_res("t6", 1, 0, 0, 1, 32'd22, 24'hAA3F3F);
      launch(32'd20, 32'd30, 8'h40);
      wait_res("t6");
      chk("t6_attempts", tried.size(), 3);

      // 7: target FF passes unless byte0 or byte1 is FF
      hmap.delete();
      hmap[32'd40] = 24'h0000FF; hmap[32'd41] = 24'h00FF00; hmap[32'd42] = 24'hFFFEFE;
      expect_res("t7", 1, 0, 0, 1, 32'd42, 24'hFFFEFE);
      launch(32'd40, 32'd45, 8'hFF);
      wait_res("t7");
      chk("t7_attempts", tried.size(), 3);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
